div_unit: RTL and testbench

Iterative 32-bit radix-2 restoring divider for the execute stage. Serves DIV/DIVU: takes operands when a divide sits in E and raises `stall_divE` toward the hazard unit, which freezes F/D/E for the duration. Delivers quotient (LO) and remainder (HI) in a one-cycle DONE window, during which the stall drops and the instruction advances to M carrying the HI/LO write.

---
 rtl/div_unit_if.sv | 21 ++
 rtl/div_unit.sv | 124 ++++++++++++
 tb/tb_div_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Execute-stage handshake between the pipeline and the iterative divider.
interface div_unit_if;
    logic        divE;
    logic        div_signedE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        cancelE;
    logic        stall_divE;
    logic        div_valid;
    logic [63:0] div_result;

    modport master (
        output divE, div_signedE, srcaE, srcbE, cancelE,
        input  stall_divE, div_valid, div_result
    );

    modport slave (
        input  divE, div_signedE, srcaE, srcbE, cancelE,
        output stall_divE, div_valid, div_result
    );
endinterface

// File: rtl/div_unit.sv
// 32-bit radix-2 restoring divider for DIV/DIVU: 1 start cycle, 32 BUSY steps, then a 1-cycle DONE window.
module div_unit (
    input  logic       clk,
    input  logic       resetn,
    div_unit_if.slave  dif
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            dz_q, dz_d;
    logic [2*W-1:0]  res_q, res_d;
    logic            valid_q, valid_d;

    logic [W:0]      trial;
    logic [W-1:0]    diff;
    logic            fits;
    logic [W-1:0]    rem_step, quo_step, q_fix, r_fix;
    logic [W-1:0]    a_abs, b_abs;
    logic            start_c;

    // One restoring step on the current {rem, quo} pair.
    always_comb begin
        trial    = {rem_q, quo_q[W-1]};
        diff     = trial[W-1:0] - dvs_q;
        fits     = (trial >= {1'b0, dvs_q});
        rem_step = fits ? diff : trial[W-1:0];
        quo_step = {quo_q[W-2:0], fits};
        q_fix    = qneg_q ? -quo_step : quo_step;
        r_fix    = rneg_q ? -rem_step : rem_step;
    end

    always_comb begin
        a_abs   = (dif.div_signedE && dif.srcaE[W-1]) ? -dif.srcaE : dif.srcaE;
        b_abs   = (dif.div_signedE && dif.srcbE[W-1]) ? -dif.srcbE : dif.srcbE;
        start_c = (state_q == IDLE) && dif.divE && !dif.cancelE;
    end

    // With a zero divisor every trial fits, so a raw dividend naturally yields {a, all-ones}.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        res_d   = res_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    rem_d   = '0;
                    dz_d    = (dif.srcbE == '0);
                    quo_d   = (dif.div_signedE && dif.srcbE != '0) ? a_abs : dif.srcaE;
                    dvs_d   = b_abs;
                    qneg_d  = dif.div_signedE && (dif.srcaE[W-1] ^ dif.srcbE[W-1]);
                    rneg_d  = dif.div_signedE && dif.srcaE[W-1];
                end
            end
            BUSY: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    res_d   = dz_q ? {rem_step, quo_step} : {r_fix, q_fix};
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (dif.cancelE) begin
            state_d = IDLE;
            valid_d = 1'b0;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    // Stall is decoded from state and inputs only, never from div_valid.
    assign dif.stall_divE = start_c || (state_q == BUSY);
    assign dif.div_valid  = valid_q;
    assign dif.div_result = res_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed spec cases plus random DIV/DIVU against an arithmetic model.
module tb_div_unit;
    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] last_exp = 64'h0;

    div_unit_if dif();

    div_unit u_dut (
        .clk    (clk),
        .resetn (resetn),
        .dif    (dif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, remainder takes dividend sign.
    function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [31:0] q, r;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (sg) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
    endfunction

    // Monitor: every valid cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (resetn && dif.div_valid) begin
            if (sb_q.size() == 0) begin
                check(1'b0, "unexpected_valid", 64'(cyc), 64'h0);
            end else begin
                e = sb_q.pop_front();
                check(dif.div_result == e.res, "result", dif.div_result, e.res);
                check(cyc == e.cyc, "valid_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Issue one divide at a negedge; returns at the negedge of the cycle after DONE with divE still high.
    task automatic do_div(input bit sg, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        exp_t e;
        int n;
        dif.divE        = 1'b1;
        dif.div_signedE = sg;
        dif.srcaE       = a;
        dif.srcbE       = b;
        dif.cancelE     = 1'b0;
        e.res = exp;
        e.cyc = cyc + 33;
        sb_q.push_back(e);
        last_exp = exp;
        n = 0;
        while (n < 100) begin
            #1;
            if (!dif.stall_divE) break;
            n++;
            @(negedge clk);
        end
        check(n == 33, "stall_len", 64'(n), 64'd33);
        @(negedge clk);
    endtask

    task automatic go_idle();
        dif.divE    = 1'b0;
        dif.cancelE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b;
        bit sg;

        resetn          = 1'b0;
        dif.divE        = 1'b0;
        dif.div_signedE = 1'b0;
        dif.srcaE       = '0;
        dif.srcbE       = '0;
        dif.cancelE     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check(dif.div_valid == 1'b0, "rst_valid", 64'(dif.div_valid), 64'h0);
        check(dif.div_result == 64'h0, "rst_result", dif.div_result, 64'h0);
        check(dif.stall_divE == 1'b0, "rst_stall", 64'(dif.stall_divE), 64'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // cancelE together with divE in IDLE must not start
        dif.divE = 1'b1; dif.cancelE = 1'b1; dif.srcaE = 32'd5; dif.srcbE = 32'd1;
        #1;
        check(dif.stall_divE == 1'b0, "cancel_idle_stall", 64'(dif.stall_divE), 64'h0);
        @(negedge clk);
        go_idle();
        @(negedge clk);

        do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        go_idle();
        @(negedge clk);
        do_div(1'b1, 32'hFFFF_FFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD);
        do_div(1'b0, 32'hFFFF_FFFF, 32'h10, 64'h0000000F_0FFFFFFF);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000);
        do_div(1'b1, 32'h1234, 32'h0, 64'h00001234_FFFFFFFF);
        do_div(1'b0, 32'h1234, 32'h0, 64'h00001234_FFFFFFFF);
        go_idle();
        @(negedge clk);

        // Cancel in BUSY cycle 10; new divide on cycle 12
        dif.divE = 1'b1; dif.div_signedE = 1'b0; dif.srcaE = 32'd1000; dif.srcbE = 32'd3;
        repeat (10) @(negedge clk);
        dif.cancelE = 1'b1;
        #1;
        check(dif.stall_divE == 1'b1, "cancel_c10_stall", 64'(dif.stall_divE), 64'h1);
        @(negedge clk);
        go_idle();
        #1;
        check(dif.stall_divE == 1'b0, "cancel_c11_stall", 64'(dif.stall_divE), 64'h0);
        check(dif.div_result == last_exp, "cancel_result_hold", dif.div_result, last_exp);
        @(negedge clk);
        do_div(1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D);

        // Back-to-back divides, then reset during a third
        do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003);
        do_div(1'b0, 32'd10, 32'd4, 64'h00000002_00000002);
        dif.srcaE = 32'd77; dif.srcbE = 32'd5;
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        go_idle();
        #1;
        check(dif.div_valid == 1'b0, "midrst_valid", 64'(dif.div_valid), 64'h0);
        check(dif.div_result == 64'h0, "midrst_result", dif.div_result, 64'h0);
        check(dif.stall_divE == 1'b0, "midrst_stall", 64'(dif.stall_divE), 64'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        do_div(1'b0, 32'd77, 32'd5, 64'h00000002_0000000F);

        // Random DIV/DIVU, including zero and small divisors
        for (int i = 0; i < 16; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            do_div(sg, a, b, ref_div(sg, a, b));
            if ($urandom_range(0, 1) == 1) begin
                go_idle();
                @(negedge clk);
            end
        end
        go_idle();
        repeat (5) @(negedge clk);
        check(sb_q.size() == 0, "sb_drained", 64'(sb_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
